display_packet_scheduler: RTL

//  Packs image, bbox and logo streams into the single 64-bit packet stream the display annotator consumes.

---
 rtl/display_sched_pkg.sv | 29 ++
 rtl/display_sched_out_reg.sv | 39 +++
 rtl/display_packet_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/display_sched_pkg.sv
// Shared definitions for the display packet scheduler and the annotator decode:
// packet type codes, scheduler states and payload-length helpers.
package display_sched_pkg;

  localparam logic [2:0] TYPE_IMAGE = 3'd1;
  localparam logic [2:0] TYPE_BBOX  = 3'd2;
  localparam logic [2:0] TYPE_LOGO  = 3'd3;

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_FILL,
    S_DRAIN,
    S_PAD
  } state_t;

  // Two pixels are packed per 64-bit word.
  function automatic logic [CNT_W-1:0] img_len(input int width, input int height);
    return CNT_W'((width * height) / 2);
  endfunction

  function automatic logic [CNT_W-1:0] logo_len(input int width, input int height);
    return CNT_W'((width * height) / 2);
  endfunction

endpackage

// File: rtl/display_sched_out_reg.sv
// Single 64+1-bit output register with valid/ready hold: loads whenever it is
// empty or being drained, holds its word while the consumer stalls.
module display_sched_out_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic        load_last,
  input  logic        out_ready,
  output logic        can_load,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        out_last
);

  logic        valid_reg;
  logic [63:0] data_reg;
  logic        last_reg;

  assign can_load  = ~valid_reg | out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_last  = last_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (can_load) begin
      valid_reg <= load;
      if (load) begin
        data_reg <= load_data;
        last_reg <= load_last;
      end
    end
  end

endmodule

// File: rtl/display_packet_scheduler.sv
// Packs image, bbox and logo sources into header/payload/pad packets of fixed length.
// Optional DISPLAY_SCHED_FRAME_ID_EN adds a frame counter in image headers and a frame_id port.
module display_packet_scheduler
  import display_sched_pkg::*;
#(
  parameter int FRAME_WIDTH  = 540,
  parameter int FRAME_HEIGHT = 540,
  parameter int MAX_BBOX     = 16,
  parameter int LOGO_WIDTH   = 540,
  parameter int LOGO_HEIGHT  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        img_valid,
  input  logic [63:0] img_data,
  input  logic        img_last,
  output logic        img_ready,
  input  logic        bbox_valid,
  input  logic [63:0] bbox_data,
  input  logic        bbox_last,
  output logic        bbox_ready,
  input  logic        logo_valid,
  input  logic [63:0] logo_data,
  input  logic        logo_last,
  output logic        logo_ready,
  input  logic        logo_req,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        err_short,
  output logic        err_long
`ifdef DISPLAY_SCHED_FRAME_ID_EN
  ,
  output logic [15:0] frame_id
`endif
);

  localparam logic [CNT_W-1:0] IMG_LEN  = img_len(FRAME_WIDTH, FRAME_HEIGHT);
  localparam logic [CNT_W-1:0] LOGO_LEN = logo_len(LOGO_WIDTH, LOGO_HEIGHT);
  localparam logic [CNT_W-1:0] BBOX_LEN = CNT_W'(MAX_BBOX);

  state_t           state_reg, state_next;
  logic [2:0]       sel_reg, sel_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rr_reg, rr_next;       // 0: bbox preferred, 1: image preferred
  logic             logo_pend_reg, logo_pend_next;
  logic             err_short_reg, err_short_next;
  logic             err_long_reg, err_long_next;
  logic             pad_sent_reg, pad_sent_next;

  logic             can_load;
  logic             load;
  logic [63:0]      load_data;
  logic             load_last;
  logic             take;
  logic             src_valid;
  logic [63:0]      src_data;
  logic             src_last;
  logic [CNT_W-1:0] len;
  logic             at_final;
  logic [63:0]      hdr;

`ifdef DISPLAY_SCHED_FRAME_ID_EN
  logic [15:0]      frame_reg;
  assign frame_id = frame_reg;
`endif

  always_comb begin
    src_valid = 1'b0;
    src_data  = '0;
    src_last  = 1'b0;
    len       = BBOX_LEN;
    case (sel_reg)
      TYPE_IMAGE: begin src_valid = img_valid;  src_data = img_data;  src_last = img_last;  len = IMG_LEN;  end
      TYPE_BBOX:  begin src_valid = bbox_valid; src_data = bbox_data; src_last = bbox_last; len = BBOX_LEN; end
      TYPE_LOGO:  begin src_valid = logo_valid; src_data = logo_data; src_last = logo_last; len = LOGO_LEN; end
      default: ;
    endcase
  end

  assign at_final = (cnt_reg == len - 1'b1);

  always_comb begin
    hdr = {61'b0, sel_reg};
`ifdef DISPLAY_SCHED_FRAME_ID_EN
    if (sel_reg == TYPE_IMAGE) hdr[31:16] = frame_reg;
`endif
  end

  assign img_ready  = take & (sel_reg == TYPE_IMAGE);
  assign bbox_ready = take & (sel_reg == TYPE_BBOX);
  assign logo_ready = take & (sel_reg == TYPE_LOGO);
  assign busy       = (state_reg != S_IDLE);
  assign err_short  = err_short_reg;
  assign err_long   = err_long_reg;

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    cnt_next       = cnt_reg;
    rr_next        = rr_reg;
    logo_pend_next = logo_pend_reg | logo_req;
    err_short_next = err_short_reg;
    err_long_next  = err_long_reg;
    pad_sent_next  = pad_sent_reg;
    load           = 1'b0;
    load_data      = '0;
    load_last      = 1'b0;
    take           = 1'b0;
    case (state_reg)
      S_IDLE: begin
        // A request arriving alongside the logo grant is served by that grant.
        if (logo_pend_reg) begin
          sel_next       = TYPE_LOGO;
          logo_pend_next = 1'b0;
          state_next     = S_HDR;
        end else if (bbox_valid && (!img_valid || !rr_reg)) begin
          sel_next   = TYPE_BBOX;
          rr_next    = 1'b1;
          state_next = S_HDR;
        end else if (img_valid) begin
          sel_next   = TYPE_IMAGE;
          rr_next    = 1'b0;
          state_next = S_HDR;
        end
      end
      S_HDR: begin
        if (can_load) begin
          load       = 1'b1;
          load_data  = hdr;
          cnt_next   = '0;
          state_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        take = can_load;
        if (src_valid && can_load) begin
          load      = 1'b1;
          load_data = src_data;
          cnt_next  = cnt_reg + 1'b1;
          if (src_last) begin
            if (at_final) begin
              state_next = S_PAD;
            end else begin
              err_short_next = 1'b1;
              state_next     = S_FILL;
            end
          end else if (at_final) begin
            err_long_next = 1'b1;
            state_next    = S_DRAIN;
          end
        end
      end
      S_FILL: begin
        if (can_load) begin
          load     = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (at_final) state_next = S_PAD;
        end
      end
      S_DRAIN: begin
        take = 1'b1;
        if (src_valid && src_last) state_next = S_PAD;
      end
      S_PAD: begin
        if (!pad_sent_reg) begin
          if (can_load) begin
            load          = 1'b1;
            load_last     = 1'b1;
            pad_sent_next = 1'b1;
          end
        end else if (out_ready) begin
          pad_sent_next = 1'b0;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      sel_reg       <= '0;
      cnt_reg       <= '0;
      rr_reg        <= 1'b0;
      logo_pend_reg <= 1'b0;
      err_short_reg <= 1'b0;
      err_long_reg  <= 1'b0;
      pad_sent_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      cnt_reg       <= cnt_next;
      rr_reg        <= rr_next;
      logo_pend_reg <= logo_pend_next;
      err_short_reg <= err_short_next;
      err_long_reg  <= err_long_next;
      pad_sent_reg  <= pad_sent_next;
    end
  end

`ifdef DISPLAY_SCHED_FRAME_ID_EN
  // Header carries the pre-increment count; the counter wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_reg <= '0;
    end else if (state_reg == S_HDR && can_load && sel_reg == TYPE_IMAGE) begin
      frame_reg <= frame_reg + 16'd1;
    end
  end
`endif

  display_sched_out_reg u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .out_ready (out_ready),
    .can_load  (can_load),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule
